// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit with HI/LO result registers.
// Optional feature: define MULT_DIV_DIVZERO_EN for early divide-by-zero termination with a div_zero pulse.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_start,
   input  logic        div_start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done
`ifdef MULT_DIV_DIVZERO_EN
   ,
   output logic        div_zero
`endif
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [W:0]      acc_q;
   logic [W-1:0]    q_q;
   logic            qm1_q;
   logic [W-1:0]    mcand_q;
   logic [W-1:0]    rem_q;
   logic [W-1:0]    dvsr_q;
   logic            sign_a_q;
   logic            sign_b_q;
   logic [W-1:0]    hi_q;
   logic [W-1:0]    lo_q;
   logic            busy_q;
   logic            done_q;
`ifdef MULT_DIV_DIVZERO_EN
   logic            dz_q;
   logic            div_zero_q;
`endif

   logic [W:0]      booth_acc_d;
   logic [W:0]      acc_d;
   logic [W-1:0]    mq_d;
   logic            qm1_d;
   logic [W:0]      rem_sh_d;
   logic [W+1:0]    diff_d;
   logic [W-1:0]    rem_d;
   logic [W-1:0]    dq_d;
   logic [W-1:0]    abs_a_d;
   logic [W-1:0]    abs_b_d;
   logic [W-1:0]    quo_fix_d;
   logic [W-1:0]    rem_fix_d;

   // Booth step: conditional add/subtract of the sign-extended multiplicand, then arithmetic shift right.
   always_comb begin
      booth_acc_d = acc_q;
      unique case ({q_q[0], qm1_q})
         2'b01:   booth_acc_d = acc_q + {mcand_q[W-1], mcand_q};
         2'b10:   booth_acc_d = acc_q - {mcand_q[W-1], mcand_q};
         default: booth_acc_d = acc_q;
      endcase
      acc_d = {booth_acc_d[W], booth_acc_d[W:1]};
      mq_d  = {booth_acc_d[0], q_q[W-1:1]};
      qm1_d = q_q[0];
   end

   // Restoring division step; the remainder stays below the divisor so 32 bits hold it between steps.
   always_comb begin
      rem_sh_d = {rem_q, q_q[W-1]};
      diff_d   = {1'b0, rem_sh_d} - {2'b00, dvsr_q};
      rem_d    = rem_sh_d[W-1:0];
      dq_d     = {q_q[W-2:0], 1'b0};
      if (!diff_d[W+1]) begin
         rem_d = diff_d[W-1:0];
         dq_d  = {q_q[W-2:0], 1'b1};
      end
   end

   // Operand magnitudes (0x80000000 maps to itself as unsigned) and sign fix-up of the final result.
   always_comb begin
      abs_a_d   = a[W-1] ? (~a + 32'd1) : a;
      abs_b_d   = b[W-1] ? (~b + 32'd1) : b;
      quo_fix_d = (sign_a_q ^ sign_b_q) ? (~q_q + 32'd1) : q_q;
      rem_fix_d = sign_a_q ? (~rem_q + 32'd1) : rem_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         q_q        <= '0;
         qm1_q      <= 1'b0;
         mcand_q    <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
         dz_q       <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (mult_start) begin
                  acc_q   <= '0;
                  q_q     <= a;
                  qm1_q   <= 1'b0;
                  mcand_q <= b;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_MULT;
               end else if (div_start) begin
                  sign_a_q <= a[W-1];
                  sign_b_q <= b[W-1];
                  q_q      <= abs_a_d;
                  dvsr_q   <= abs_b_d;
                  rem_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_DIV;
`ifdef MULT_DIV_DIVZERO_EN
                  dz_q     <= (b == 32'd0);
`endif
               end
            end
            S_MULT: begin
               acc_q <= acc_d;
               q_q   <= mq_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  hi_q    <= acc_d[W-1:0];
                  lo_q    <= mq_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DIV: begin
`ifdef MULT_DIV_DIVZERO_EN
               if (dz_q) begin
                  done_q     <= 1'b1;
                  div_zero_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  rem_q <= rem_d;
                  q_q   <= dq_d;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) state_q <= S_FIX;
               end
`else
               rem_q <= rem_d;
               q_q   <= dq_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_FIX;
`endif
            end
            S_FIX: begin
               hi_q    <= rem_fix_d;
               lo_q    <= quo_fix_d;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
`ifdef MULT_DIV_DIVZERO_EN
               dz_q       <= 1'b0;
               div_zero_q <= 1'b0;
`endif
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;
`ifdef MULT_DIV_DIVZERO_EN
   assign div_zero = div_zero_q;
`endif

endmodule
